// File: rtl/pre_if_stage.sv
// Pre-fetch (PFS) stage, directly upstream of the IF stage.
//
// Generates the next fetch PC and issues it on the SRAM-like instruction
// interface (req / addr_ok / data_ok). If a response comes back before IF can
// accept the entry, it is held in a local buffer, and IF receives it with
// inst_ok=1. Exception, eret and taken-branch redirects are applied here.
// Responses to fetches that are already in flight when a redirect occurs are
// dropped by a small cancel counter.
//
// Optional feature (define PFS_ADDR_EX_EN): a misaligned PC is not requested.
// It completes immediately with inst_ok=1 and inst=0, so that IF can raise
// the AdEL fetch exception for that PC. With the macro undefined, every PC is
// requested.
//
// Ports:
//   clk, resetn             clock, asynchronous active-low reset
//   fs_allowin              IF can accept a new entry this cycle
//   fs_valid_o              IF holds a valid entry
//   fs_inst_waiting         IF has an issued request still awaiting data_ok
//   fs_inst_unable          IF has no outstanding request of its own
//   pfs_to_fs_valid/_bus    entry to IF: {inst_ok, inst, pc}
//   br_bus                  {br_stall, br_taken, br_target} from ID
//   ws_ex, ws_eret, cp0_epc flush requests from WB and the eret target
//   inst_sram_*             instruction SRAM-like master interface
module pre_if_stage #(
  parameter logic [31:0] RESET_PC = 32'hBFC00000,
  parameter logic [31:0] EX_ENTRY = 32'hBFC00380
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        fs_allowin,
  input  logic        fs_valid_o,
  input  logic        fs_inst_waiting,
  input  logic        fs_inst_unable,
  output logic        pfs_to_fs_valid,
  output logic [64:0] pfs_to_fs_bus,
  input  logic [33:0] br_bus,
  input  logic        ws_ex,
  input  logic        ws_eret,
  input  logic [31:0] cp0_epc,
  output logic        inst_sram_req,
  output logic        inst_sram_wr,
  output logic [1:0]  inst_sram_size,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic        inst_sram_addr_ok,
  input  logic        inst_sram_data_ok,
  input  logic [31:0] inst_sram_rdata
);

  typedef enum logic [1:0] {StReq, StWait, StDone} state_e;

  state_e      state_q, state_d;
  logic [31:0] pfs_pc_q, pfs_pc_d;
  logic [31:0] inst_buf_q, inst_buf_d;
  logic        inst_ok_q, inst_ok_d;
  logic [1:0]  cancel_cnt_q, cancel_cnt_d;
  logic        br_buf_valid_q, br_buf_valid_d;
  logic [31:0] br_target_buf_q, br_target_buf_d;

  logic        br_stall, br_taken;
  logic [31:0] br_target;
  logic        flush;
  logic [31:0] flush_pc;
  logic        cancel_busy;
  logic        issue_ok;
  logic        pc_misaligned;
  logic        addr_hs;
  logic        br_redirect;
  logic        br_delay;
  logic        xfer;
  logic        resp_drop;
  logic        resp_fs;
  logic        resp_pfs;
  logic        pfs_pending;
  logic        fs_pending;
  logic [31:0] seq_pc;
  logic [1:0]  cancel_inc;
  logic [2:0]  cancel_sum;

  assign {br_stall, br_taken, br_target} = br_bus;

  assign flush       = ws_ex | ws_eret;
  assign flush_pc    = ws_ex ? EX_ENTRY : cp0_epc;
  assign cancel_busy = (cancel_cnt_q != 2'd0);

  // Hold off while the branch outcome is unknown: pfs_pc may be the
  // successor of a delay slot. Also hold off while stale responses are owed.
  assign issue_ok = (state_q == StReq) && !br_stall && !cancel_busy;

`ifdef PFS_ADDR_EX_EN
  assign pc_misaligned = (pfs_pc_q[1:0] != 2'b00);
`else
  assign pc_misaligned = 1'b0;
`endif

  assign inst_sram_req   = resetn && issue_ok && !pc_misaligned;
  assign inst_sram_wr    = 1'b0;
  assign inst_sram_size  = 2'd2;
  assign inst_sram_addr  = pfs_pc_q;
  assign inst_sram_wdata = 32'd0;

  assign addr_hs = inst_sram_req && inst_sram_addr_ok;

  // With the delay slot already in IF, the PFS entry is wrong-path.
  // Without it, pfs_pc is the delay slot and the target is taken after it.
  assign br_redirect = br_taken && !br_stall && fs_valid_o;
  assign br_delay    = br_taken && !br_stall && !fs_valid_o;

  assign pfs_to_fs_valid = ((state_q == StWait) || (state_q == StDone)) &&
                           !flush && !cancel_busy && !br_redirect;
  assign pfs_to_fs_bus   = pfs_to_fs_valid ? {inst_ok_q, inst_buf_q, pfs_pc_q} : 65'd0;
  assign xfer            = pfs_to_fs_valid && fs_allowin;

  // data_ok ownership. A response that coincides with a WAIT-state handoff
  // travels with the entry into IF, so PFS does not capture it.
  assign resp_drop = inst_sram_data_ok && cancel_busy;
  assign resp_fs   = inst_sram_data_ok && !cancel_busy && fs_inst_waiting;
  assign resp_pfs  = inst_sram_data_ok && !cancel_busy && !fs_inst_waiting &&
                     (state_q == StWait) && !xfer;

  // Requests whose responses are still owed at the end of this cycle.
  // An addr_ok that coincides with a redirect still counts as accepted.
  assign pfs_pending = ((state_q == StWait) && !resp_pfs) || addr_hs;
  assign fs_pending  = fs_inst_waiting && !fs_inst_unable && !resp_fs;

  always_comb begin
    cancel_inc = 2'd0;
    if (flush) begin
      cancel_inc = {1'b0, pfs_pending} + {1'b0, fs_pending};
    end else if (br_redirect) begin
      cancel_inc = {1'b0, pfs_pending};
    end
  end

  assign cancel_sum   = {1'b0, cancel_cnt_q} + {1'b0, cancel_inc} - {2'b00, resp_drop};
  // Saturate rather than wrap; real traffic never exceeds 2.
  assign cancel_cnt_d = cancel_sum[2] ? 2'd3 : cancel_sum[1:0];

  always_comb begin
    seq_pc = pfs_pc_q + 32'd4;
    if (br_buf_valid_q) begin
      seq_pc = br_target_buf_q;
    end else if (br_delay) begin
      seq_pc = br_target;
    end
  end

  always_comb begin
    state_d         = state_q;
    pfs_pc_d        = pfs_pc_q;
    inst_buf_d      = inst_buf_q;
    inst_ok_d       = inst_ok_q;
    br_buf_valid_d  = br_buf_valid_q;
    br_target_buf_d = br_target_buf_q;

    unique case (state_q)
      StReq: begin
        if (issue_ok && pc_misaligned) begin
          // Complete at once with a null instruction; IF flags AdEL.
          state_d    = StDone;
          inst_ok_d  = 1'b1;
          inst_buf_d = 32'd0;
        end else if (addr_hs) begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (resp_pfs) begin
          state_d    = StDone;
          inst_buf_d = inst_sram_rdata;
          inst_ok_d  = 1'b1;
        end
      end
      StDone: begin
        state_d = StDone;
      end
      default: begin
        state_d = StReq;
      end
    endcase

    if (br_delay) begin
      br_buf_valid_d  = 1'b1;
      br_target_buf_d = br_target;
    end

    if (xfer) begin
      pfs_pc_d       = seq_pc;
      state_d        = StReq;
      inst_ok_d      = 1'b0;
      br_buf_valid_d = 1'b0;
    end

    if (br_redirect) begin
      pfs_pc_d  = br_target;
      state_d   = StReq;
      inst_ok_d = 1'b0;
    end

    if (flush) begin
      pfs_pc_d       = flush_pc;
      state_d        = StReq;
      inst_ok_d      = 1'b0;
      br_buf_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q         <= StReq;
      pfs_pc_q        <= RESET_PC;
      inst_buf_q      <= 32'd0;
      inst_ok_q       <= 1'b0;
      cancel_cnt_q    <= 2'd0;
      br_buf_valid_q  <= 1'b0;
      br_target_buf_q <= 32'd0;
    end else begin
      state_q         <= state_d;
      pfs_pc_q        <= pfs_pc_d;
      inst_buf_q      <= inst_buf_d;
      inst_ok_q       <= inst_ok_d;
      cancel_cnt_q    <= cancel_cnt_d;
      br_buf_valid_q  <= br_buf_valid_d;
      br_target_buf_q <= br_target_buf_d;
    end
  end

endmodule

// File: tb/tb_pre_if_stage.sv
// Testbench for pre_if_stage: a scoreboard of expected fetch addresses and
// IF handoffs, fed by a one-cycle-latency instruction memory model and a
// minimal model of IF's outstanding-request tracking.
module tb_pre_if_stage;

  logic        clk;
  logic        resetn;
  logic        fs_allowin;
  logic        fs_valid_o;
  logic        fs_inst_waiting;
  logic        fs_inst_unable;
  logic        pfs_to_fs_valid;
  logic [64:0] pfs_to_fs_bus;
  logic [33:0] br_bus;
  logic        ws_ex;
  logic        ws_eret;
  logic [31:0] cp0_epc;
  logic        inst_sram_req;
  logic        inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;

  pre_if_stage u_dut (
    .clk               (clk),
    .resetn            (resetn),
    .fs_allowin        (fs_allowin),
    .fs_valid_o        (fs_valid_o),
    .fs_inst_waiting   (fs_inst_waiting),
    .fs_inst_unable    (fs_inst_unable),
    .pfs_to_fs_valid   (pfs_to_fs_valid),
    .pfs_to_fs_bus     (pfs_to_fs_bus),
    .br_bus            (br_bus),
    .ws_ex             (ws_ex),
    .ws_eret           (ws_eret),
    .cp0_epc           (cp0_epc),
    .inst_sram_req     (inst_sram_req),
    .inst_sram_wr      (inst_sram_wr),
    .inst_sram_size    (inst_sram_size),
    .inst_sram_addr    (inst_sram_addr),
    .inst_sram_wdata   (inst_sram_wdata),
    .inst_sram_addr_ok (inst_sram_addr_ok),
    .inst_sram_data_ok (inst_sram_data_ok),
    .inst_sram_rdata   (inst_sram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_vec;
  int unsigned n_err;

  logic [31:0] exp_addr_q[$];
  logic [64:0] exp_hand_q[$];
  logic [31:0] resp_q[$];
  logic        if_wait;
  int unsigned exp_drop;
  logic        hold;

  task automatic check_eq(input string tag, input logic [64:0] got, input logic [64:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return a ^ 32'h1234_5678;
  endfunction

  function automatic logic [64:0] hand(input logic ok, input logic [31:0] inst,
                                      input logic [31:0] pc);
    return {ok, inst, pc};
  endfunction

  // Drive the memory response and IF status, just after a rising edge.
  task automatic drive();
    fs_inst_waiting = if_wait;
    fs_inst_unable  = !if_wait;
    if (resp_q.size() > 0 && !hold) begin
      inst_sram_data_ok = 1'b1;
      inst_sram_rdata   = mem_data(resp_q[0]);
    end else begin
      inst_sram_data_ok = 1'b0;
      inst_sram_rdata   = 32'd0;
    end
  endtask

  // Observe the settled cycle on the falling edge and score its events.
  task automatic observe();
    logic        xfer;
    logic        took;
    logic [64:0] got;
    logic [64:0] exp;
    xfer = pfs_to_fs_valid && fs_allowin;
    took = 1'b0;
    if (inst_sram_data_ok) begin
      resp_q.delete(0);
      if (exp_drop > 0) exp_drop--;
      else if (if_wait) if_wait = 1'b0;
      else if (xfer && !pfs_to_fs_bus[64]) took = 1'b1;
    end
    if (inst_sram_req && inst_sram_addr_ok) begin
      if (exp_addr_q.size() == 0) begin
        check_eq("addr_extra", 65'(exp_addr_q.size()), 65'd1);
      end else begin
        check_eq("fetch_addr", 65'(inst_sram_addr), 65'(exp_addr_q.pop_front()));
      end
      resp_q.push_back(inst_sram_addr);
    end
    if (xfer) begin
      if (exp_hand_q.size() == 0) begin
        check_eq("hand_extra", 65'(exp_hand_q.size()), 65'd1);
      end else begin
        exp = exp_hand_q.pop_front();
        got = pfs_to_fs_bus;
        if (!exp[64]) got[63:32] = 32'd0;  // inst is don't-care without inst_ok
        check_eq("handoff", got, exp);
      end
      if (!pfs_to_fs_bus[64] && !took) if_wait = 1'b1;
    end
  endtask

  task automatic cyc_a();
    drive();
    @(negedge clk);
    observe();
  endtask

  task automatic cyc_b();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    cyc_a();
    cyc_b();
  endtask

  task automatic check_reset();
    check_eq("rst_req",   65'(inst_sram_req),   65'd0);
    check_eq("rst_valid", 65'(pfs_to_fs_valid), 65'd0);
    check_eq("rst_bus",   pfs_to_fs_bus,        65'd0);
    check_eq("rst_addr",  65'(inst_sram_addr),  65'h0_BFC0_0000);
    check_eq("rst_size",  65'(inst_sram_size),  65'd2);
    check_eq("rst_wr",    65'(inst_sram_wr),    65'd0);
    check_eq("rst_wdata", 65'(inst_sram_wdata), 65'd0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    if_wait = 1'b0;
    exp_drop = 0;
    hold = 1'b0;
    resetn = 1'b0;
    fs_allowin = 1'b1;
    fs_valid_o = 1'b0;
    br_bus = 34'd0;
    ws_ex = 1'b0;
    ws_eret = 1'b0;
    cp0_epc = 32'd0;
    inst_sram_addr_ok = 1'b1;
    drive();
    repeat (2) @(posedge clk);
    #1;
    cyc_a();
    check_reset();
    cyc_b();
    resetn = 1'b1;

    // Sequential fetch with immediate handoff in WAIT.
    for (int i = 0; i < 3; i++) begin
      exp_addr_q.push_back(32'hBFC0_0000 + 32'(4 * i));
      exp_hand_q.push_back(hand(1'b0, 32'd0, 32'hBFC0_0000 + 32'(4 * i)));
    end
    repeat (6) tick();

    // IF stalled: response buffered, handed off with inst_ok=1.
    fs_allowin = 1'b0;
    exp_addr_q.push_back(32'hBFC0_000C);
    tick();
    tick();
    cyc_a();
    check_eq("done_valid", 65'(pfs_to_fs_valid), 65'd1);
    check_eq("done_bus", pfs_to_fs_bus, hand(1'b1, mem_data(32'hBFC0_000C), 32'hBFC0_000C));
    cyc_b();
    fs_allowin = 1'b1;
    exp_hand_q.push_back(hand(1'b1, mem_data(32'hBFC0_000C), 32'hBFC0_000C));
    exp_addr_q.push_back(32'hBFC0_0010);
    tick();

    // Exception while PFS and IF both have a response outstanding.
    hold = 1'b1;
    tick();
    exp_hand_q.push_back(hand(1'b0, 32'd0, 32'hBFC0_0010));
    tick();
    exp_addr_q.push_back(32'hBFC0_0014);
    tick();
    ws_ex = 1'b1;
    cyc_a();
    check_eq("ex_valid", 65'(pfs_to_fs_valid), 65'd0);
    cyc_b();
    ws_ex = 1'b0;
    if_wait = 1'b0;
    exp_drop = 2;
    hold = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cyc_a();
      check_eq("ex_cancel_req", 65'(inst_sram_req), 65'd0);
      cyc_b();
    end
    exp_addr_q.push_back(32'hBFC0_0380);
    tick();
    exp_hand_q.push_back(hand(1'b0, 32'd0, 32'hBFC0_0380));
    tick();

    // eret while holding a completed fetch: discarded, no cancel.
    fs_allowin = 1'b0;
    exp_addr_q.push_back(32'hBFC0_0384);
    tick();
    tick();
    ws_eret = 1'b1;
    cp0_epc = 32'hBFC0_0100;
    cyc_a();
    check_eq("eret_valid", 65'(pfs_to_fs_valid), 65'd0);
    cyc_b();
    ws_eret = 1'b0;
    exp_addr_q.push_back(32'hBFC0_0100);
    cyc_a();
    check_eq("eret_req", 65'(inst_sram_req), 65'd1);
    cyc_b();
    fs_allowin = 1'b1;
    exp_hand_q.push_back(hand(1'b0, 32'd0, 32'hBFC0_0100));
    tick();

    // Taken branch with the delay slot still in PFS.
    br_bus = {1'b0, 1'b1, 32'hBFC0_0200};
    fs_valid_o = 1'b0;
    exp_addr_q.push_back(32'hBFC0_0104);
    tick();
    br_bus = 34'd0;
    exp_hand_q.push_back(hand(1'b0, 32'd0, 32'hBFC0_0104));
    tick();
    exp_addr_q.push_back(32'hBFC0_0200);
    hold = 1'b1;
    tick();

    // Taken branch with the delay slot in IF: PFS fetch in WAIT is killed.
    br_bus = {1'b0, 1'b1, 32'hBFC0_0200};
    fs_valid_o = 1'b1;
    cyc_a();
    check_eq("br_kill_valid", 65'(pfs_to_fs_valid), 65'd0);
    cyc_b();
    br_bus = 34'd0;
    fs_valid_o = 1'b0;
    hold = 1'b0;
    exp_drop = 1;
    cyc_a();
    check_eq("br_cancel_req", 65'(inst_sram_req), 65'd0);
    cyc_b();
    exp_addr_q.push_back(32'hBFC0_0200);
    tick();
    exp_hand_q.push_back(hand(1'b0, 32'd0, 32'hBFC0_0200));
    tick();

    // Branch outcome unknown: no request.
    br_bus = {1'b1, 1'b0, 32'd0};
    cyc_a();
    check_eq("stall_req", 65'(inst_sram_req), 65'd0);
    cyc_b();
    br_bus = 34'd0;

    // Reset in the middle of a fetch.
    exp_addr_q.push_back(32'hBFC0_0204);
    hold = 1'b1;
    tick();
    resetn = 1'b0;
    resp_q.delete();
    hold = 1'b0;
    cyc_a();
    check_reset();
    cyc_b();
    resetn = 1'b1;
    if_wait = 1'b0;
    exp_drop = 0;

    // eret to a misaligned PC.
    inst_sram_addr_ok = 1'b0;
    ws_eret = 1'b1;
    cp0_epc = 32'hBFC0_0102;
    tick();
    ws_eret = 1'b0;
    inst_sram_addr_ok = 1'b1;
`ifdef PFS_ADDR_EX_EN
    cyc_a();
    check_eq("adel_noreq", 65'(inst_sram_req), 65'd0);
    cyc_b();
    exp_hand_q.push_back(hand(1'b1, 32'd0, 32'hBFC0_0102));
    tick();
`else
    exp_addr_q.push_back(32'hBFC0_0102);
    cyc_a();
    check_eq("unaligned_req", 65'(inst_sram_req), 65'd1);
    cyc_b();
    exp_hand_q.push_back(hand(1'b0, 32'd0, 32'hBFC0_0102));
    tick();
`endif

    check_eq("addr_left", 65'(exp_addr_q.size()), 65'd0);
    check_eq("hand_left", 65'(exp_hand_q.size()), 65'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pre_if_stage.md
Name: pre_if_stage

Overview:
- Pre-fetch (PFS) stage, directly upstream of the IF stage.
- Generates the next PC and issues the instruction request on the SRAM-like inst interface (req/addr_ok/data_ok).
- Buffers a response that arrives before IF can accept it, so IF receives an early-completed fetch via inst_ok.
- Applies redirects: exception, eret, and taken branch after its delay slot. Cancels stale in-flight fetches.

Parameters:
- RESET_PC, 32'hBFC00000, first fetched PC after reset.
- EX_ENTRY, 32'hBFC00380, exception entry PC.

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous active-low reset.
- fs_allowin  in  1  IF can accept a new entry this cycle.
- fs_valid_o  in  1  IF holds a valid entry.
- fs_inst_waiting  in  1  IF has an issued request still awaiting data_ok.
- fs_inst_unable  in  1  IF cannot take a data_ok (no outstanding request of its own).
- pfs_to_fs_valid  out  1  PFS entry handed to IF.
- pfs_to_fs_bus  out  65  {inst_ok[64], inst[63:32], pc[31:0]}.
- br_bus  in  34  {br_stall[33], br_taken[32], br_target[31:0]}, sampled from ID.
- ws_ex  in  1  exception flush from WB.
- ws_eret  in  1  eret flush from WB.
- cp0_epc  in  32  eret target.
- inst_sram_req  out  1  request valid.
- inst_sram_wr  out  1  constant 0.
- inst_sram_size  out  2  constant 2'd2.
- inst_sram_addr  out  32  request address = pfs_pc.
- inst_sram_wdata  out  32  constant 0.
- inst_sram_addr_ok  in  1  request accepted.
- inst_sram_data_ok  in  1  response valid.
- inst_sram_rdata  in  32  response data.

Behaviour:
- Reset (async, resetn=0):
  - state=REQ, pfs_pc=RESET_PC.
  - inst_buf=0, inst_ok=0, cancel_cnt=0, br_buf_valid=0.
  - All outputs 0, except size=2 and addr=RESET_PC.
- State REQ:
  - inst_sram_req=1, unless br_stall=1 (branch outcome unknown while pfs_pc may be the delay-slot successor) or cancel_cnt!=0.
  - addr_ok with req=1 → WAIT.
- State WAIT:
  - req=0.
  - An owned data_ok captures rdata into inst_buf, sets inst_ok=1, → DONE.
- State DONE:
  - req=0; holds instruction.
- Handoff:
  - pfs_to_fs_valid=1 in WAIT or DONE when no flush and cancel_cnt==0.
  - Transfer occurs when pfs_to_fs_valid && fs_allowin.
  - On transfer: pfs_pc ← next PC, state → REQ, inst_ok ← 0.
  - A WAIT-state transfer passes ownership of the pending response to IF (inst_ok=0 on bus).
- data_ok ownership, in priority order:
  1. cancel_cnt!=0: the response is dropped and cancel_cnt decrements.
  2. fs_inst_waiting=1: the response belongs to IF.
  3. Otherwise, with state==WAIT: the response belongs to PFS.
- Next PC priority:
  - ws_ex → EX_ENTRY.
  - Else ws_eret → cp0_epc.
  - Else br_buf_valid → br_target_buf.
  - Else pfs_pc+4.
- Branch handling:
  - br_taken=1 && br_stall=0, with fs_valid_o=1: the delay slot is in IF, so the PFS entry is wrong-path. Redirect immediately: pfs_pc ← br_target, state → REQ.
    - If the PFS request was accepted but data not yet returned (WAIT), cancel_cnt increments.
    - If in DONE, discard inst_buf.
  - br_taken=1 && br_stall=0, with fs_valid_o=0: pfs_pc is the delay slot. Latch br_buf_valid=1 and br_target_buf; both are consumed at the next transfer.
- Flush (ws_ex | ws_eret):
  - Redirect pfs_pc, state → REQ, inst_ok ← 0, br_buf_valid ← 0.
  - cancel_cnt += (state==WAIT) + fs_inst_waiting. Maximum value is 2; the counter is 2 bits and never wraps.
  - Flush has priority over a simultaneous branch or transfer.
- Simultaneous events:
  - addr_ok and a flush in the same cycle count as accepted: cancel_cnt +1.
  - data_ok dropped in the same cycle as a new flush: the net cancel_cnt change is the sum of both.
- Reset mid-transaction: all state clears asynchronously. The interconnect is reset alongside, so no stale response is tracked.

Optional Feature:
- Macro: PFS_ADDR_EX_EN.
- Defined: if pfs_pc[1:0]!=0 in REQ, no request is issued. State → DONE with inst_ok=1 and inst=32'h0 immediately, so IF raises the AdEL fetch exception on that pc.
- Undefined: every pc is requested regardless of alignment.

Test Plan:
- Reset release, addr_ok=1 always, data_ok one cycle later, fs_allowin=1 → fetch addresses 0xBFC00000, 0xBFC00004, 0xBFC00008; inst_ok=0 on each handoff.
- fs_allowin=0 for 3 cycles with fs_inst_waiting=0 → data_ok captured, bus shows inst_ok=1 with rdata; handoff once fs_allowin=1; next req at pc+4.
- ws_ex during WAIT with fs_inst_waiting=1 → cancel_cnt=2; next two data_ok dropped; req to 0xBFC00380 issued after cancel_cnt reaches 0.
- ws_eret with cp0_epc=0xBFC00100 while in DONE → inst discarded; next addr=0xBFC00100; no cancel.
- br_taken with target 0xBFC00200, fs_valid_o=0, pfs_pc=0xBFC00010 → 0xBFC00010 handed off, then fetch 0xBFC00200. With fs_valid_o=1 in WAIT → cancel_cnt=1, redirect to 0xBFC00200.
- With PFS_ADDR_EX_EN, eret to 0xBFC00102 → no inst_sram_req; bus {1, 0, 0xBFC00102}.
